// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder.
package nibble_adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nib_count(input int width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle between a producer (master) and the adder (slave).
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/nibble_serial_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice; every carry is a flat sum of products.
module cla4_slice
    import nibble_adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);
    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic [NIB_W:0]   c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        // a=b=1 gives p=0, so the sum bit comes purely from the incoming carry.
        sum  = p ^ c[NIB_W-1:0];
        cout = c[NIB_W];
    end
endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that walks the operands through one CLA slice, LS nibble first,
// carrying between nibbles only through carry_q.
module nibble_serial_adder
    import nibble_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst,
    nibble_serial_adder_if.slave bus
);
    localparam int NIB   = nib_count(WIDTH);
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [NIB_W-1:0] slice_sum;
    logic             slice_cout;
    logic             accept;
    logic             step;

    cla4_slice u_slice (
        .a    (a_q[NIB_W-1:0]),
        .b    (b_q[NIB_W-1:0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        accept        = 1'b0;
        step          = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            sum_q   <= '0;
            carry_q <= bus.cin;
            cnt_q   <= '0;
        end else if (step) begin
            a_q     <= a_q >> NIB_W;
            b_q     <= b_q >> NIB_W;
            // New nibble enters at the top; after NIB steps the LS nibble has reached bit 0.
            sum_q   <= WIDTH'({slice_sum, sum_q} >> NIB_W);
            carry_q <= slice_cout;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = carry_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench: directed and random traffic on WIDTH=16, random traffic on WIDTH=4 and 32.
module tb_nibble_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_alt = 1'b1;
    logic rand_stall = 1'b0;
    logic stall_bit = 1'b1;
    logic or_manual = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;
    time  t_acc;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    nibble_serial_adder_if #(.WIDTH(16)) bus ();

    nibble_serial_adder #(.WIDTH(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always_comb bus.out_ready = rand_stall ? stall_bit : or_manual;

    always @(posedge clk) begin
        #1;
        stall_bit = ($urandom_range(0, 3) != 0);
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("w16_unexpected_result", 64'(bus.out_valid), 64'd0);
            end else begin
                chk("w16_result", 64'({bus.cout, bus.sum}), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        bit ok;
        ok = 1'b0;
        bus.a = av;
        bus.b = bv;
        bus.cin = cv;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL w16_send: in_ready stuck at 0, required 1");
        end else begin
            @(posedge clk);
            t_acc = $time;
            exp_q.push_back({1'b0, av} + {1'b0, bv} + 17'(cv));
        end
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL %s_drain: %0d results outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Secondary widths: fully random traffic with their own scoreboards.
    for (genvar g = 0; g < 2; g++) begin : g_alt
        localparam int W = (g == 0) ? 4 : 32;
        nibble_serial_adder_if #(.WIDTH(W)) abus ();
        logic [W:0] aq[$];
        logic astall = 1'b1;
        logic done_flag = 1'b0;

        nibble_serial_adder #(.WIDTH(W)) u_dut (
            .clk (clk),
            .rst (rst_alt),
            .bus (abus)
        );

        assign abus.out_ready = astall;

        always @(posedge clk) begin
            #1;
            astall = ($urandom_range(0, 3) != 0);
        end

        always @(negedge clk) begin
            if (!rst_alt && abus.out_valid && abus.out_ready) begin
                if (aq.size() == 0) begin
                    chk((W == 4) ? "w4_unexpected_result" : "w32_unexpected_result",
                        64'(abus.out_valid), 64'd0);
                end else begin
                    chk((W == 4) ? "w4_result" : "w32_result",
                        64'({abus.cout, abus.sum}), 64'(aq.pop_front()));
                end
            end
        end

        initial begin
            logic [W-1:0] av;
            logic [W-1:0] bv;
            logic         cv;
            bit           ok;
            abus.in_valid = 1'b0;
            abus.a = '0;
            abus.b = '0;
            abus.cin = 1'b0;
            wait (rst_alt == 1'b0);
            @(posedge clk);
            #1;
            for (int n = 0; n < 1000; n++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                av = W'($urandom);
                bv = W'($urandom);
                cv = 1'($urandom);
                abus.a = av;
                abus.b = bv;
                abus.cin = cv;
                abus.in_valid = 1'b1;
                ok = 1'b0;
                for (int i = 0; i < 500; i++) begin
                    @(negedge clk);
                    if (abus.in_ready) begin
                        ok = 1'b1;
                        break;
                    end
                end
                if (!ok) begin
                    n_checks++;
                    $display("FAIL w%0d_send: in_ready stuck at 0, required 1", W);
                end else begin
                    @(posedge clk);
                    aq.push_back({1'b0, av} + {1'b0, bv} + (W + 1)'(cv));
                end
                #1 abus.in_valid = 1'b0;
            end
            for (int i = 0; i < 3000; i++) begin
                if (aq.size() == 0) break;
                @(negedge clk);
            end
            if (aq.size() != 0) begin
                n_checks++;
                $display("FAIL w%0d_drain: %0d results outstanding, required 0", W, aq.size());
            end
            done_flag = 1'b1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: cycle limit exceeded, run did not complete");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        int   k;
        time  t0;
        logic stray;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_sum_cout", 64'({bus.cout, bus.sum}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rst_alt = 1'b0;

        send(16'h1234, 16'h4321, 1'b0);
        k = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            k++;
            if (bus.out_valid) break;
        end
        chk("latency_cycles", 64'(k), 64'd4);
        drain("basic");

        send(16'hFFFF, 16'h0001, 1'b0);
        drain("ripple");
        send(16'h8888, 16'h8888, 1'b1);
        drain("generate");

        send(16'h0F0F, 16'hF0F0, 1'b1);
        t0 = t_acc;
        send(16'h7FFF, 16'h7FFF, 1'b1);
        chk("throughput_cycles", 64'((t_acc - t0) / 10), 64'd6);
        drain("throughput");

        // Backpressure: result held, in_valid pulse ignored.
        or_manual = 1'b0;
        send(16'h00AF, 16'h0051, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        for (int i = 0; i < 3; i++) begin
            chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_sum_cout", 64'({bus.cout, bus.sum}), 64'h0100);
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            @(posedge clk);
            #1;
            bus.a = 16'hDEAD;
            bus.b = 16'hBEEF;
            bus.in_valid = (i == 1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        or_manual = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_in_ready", 64'(bus.in_ready), 64'd1);
        chk("release_out_valid", 64'(bus.out_valid), 64'd0);
        drain("stall");

        // Abort mid-RUN.
        send(16'hFFFF, 16'hFFFF, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_run_in_ready", 64'(bus.in_ready), 64'd1);
        chk("abort_run_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_run_sum_cout", 64'({bus.cout, bus.sum}), 64'd0);
        stray = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            stray = stray | bus.out_valid;
        end
        chk("abort_run_no_result", 64'(stray), 64'd0);
        @(posedge clk);
        #1;
        send(16'h0001, 16'h0002, 1'b0);
        drain("after_abort");

        // Abort while DONE is stalled.
        or_manual = 1'b0;
        send(16'h1111, 16'h2222, 1'b1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        or_manual = 1'b1;
        @(negedge clk);
        chk("abort_done_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_done_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        rand_stall = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(16'($urandom), 16'($urandom), 1'($urandom));
        end
        drain("random16");
        rand_stall = 1'b0;

        for (int i = 0; i < 60000; i++) begin
            if (g_alt[0].done_flag && g_alt[1].done_flag) break;
            @(negedge clk);
        end
        if (!(g_alt[0].done_flag && g_alt[1].done_flag)) begin
            n_checks++;
            $display("FAIL alt_widths_done: flags %b%b, required 11",
                     g_alt[1].done_flag, g_alt[0].done_flag);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
